flash_cal_sequencer: RTL and testbench
======================================

Name: flash_cal_sequencer

Overview:
Sequences foreground offset calibration of the flash ADC comparator bank, one comparator at a time. For the selected comparator it asserts cal_mode to short the inputs, then runs a 6-bit successive-approximation search on a signed trim code. It drives the per-comparator b_left/b_right trim bus during the search and writes each final code to the trim register file. It replaces the static per-instance CODE trim with a runtime, measured value.

Parameters:
NUM_COMP, 4, number of comparators calibrated in sequence (≥1)
SEL_W, 2, width of comp_sel/wr_addr (≥ clog2(NUM_COMP), min 1)
SETTLE_CYC, 4, clk cycles waited after each trim change before sampling cap_out (≥1)

Ports:
clk  in  1  single clock; all logic rising-edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin full calibration; honoured only in IDLE
abort  in  1  stop calibration; honoured in any non-IDLE state
cap_out  in  1  comparator output of selected comparator; clk-synchronous by construction, sampled directly
cal_mode  out  1  shorts selected comparator inputs; high while busy
comp_sel  out  SEL_W  index of comparator under calibration
b_left  out  5  live trim, negative magnitude
b_right  out  5  live trim, positive magnitude
wr_en  out  1  one-cycle write strobe to trim register file
wr_addr  out  SEL_W  comparator index for write
wr_code  out  6  signed two's-complement final trim, range -31..+31
cal_busy  out  1  high in every state except IDLE
cal_done  out  1  one-cycle pulse after last comparator written

Behaviour:
- Reset: state IDLE; all outputs 0; SAR register u=0; bit index=5.
- Trim code: u is 6-bit offset-binary; code = u−32, saturated to −31 when u=0.
- Mapping: code>0 → b_right=code, b_left=0; code<0 → b_left=−code, b_right=0; code=0 → both 0.
- Outside APPLY/SETTLE/SAMPLE, b_left=b_right=0.
- States:
  - IDLE: on start && !abort → SETUP with comp_sel=0.
  - SETUP (1 cyc): cal_mode=1; u=0; bit=5 → APPLY.
  - APPLY (1 cyc): u[bit]=1; trim bus updated; settle counter loaded with SETTLE_CYC → SETTLE.
  - SETTLE (SETTLE_CYC cyc): count down → SAMPLE.
  - SAMPLE (1 cyc): if cap_out=0, clear u[bit], else keep. If bit=0 → WRITE, else bit−1 → APPLY.
  - WRITE (1 cyc): wr_en=1, wr_addr=comp_sel, wr_code=code(u). If comp_sel=NUM_COMP−1 → DONE, else comp_sel+1 → SETUP.
  - DONE (1 cyc): cal_done=1, cal_mode=0 → IDLE.
- cap_out convention: 1 means trial code at or below comparator offset. The search therefore yields the largest code with cap_out=1.
- Latency per comparator: 2 + 6×(SETTLE_CYC+2) cycles. Default: 38 cycles; 4 comparators = 152 cycles from the cycle after start to WRITE of comp 3; cal_done in cycle 153.
- abort:
  - In any busy state: next cycle IDLE, all outputs 0, no write for the current comparator, no cal_done.
  - Writes already issued stand.
  - abort with start in IDLE: stays IDLE.
- start while busy: ignored.
- Reset mid-operation: immediate IDLE; no partial write; wr_en never glitches high.
- cap_out stuck 1: u=63, code +31. Stuck 0: u=0, code saturates to −31.

Optional Feature:
CAL_MAJORITY_EN:
- Defined: SAMPLE lasts 3 cycles; bit decision is the majority of the 3 cap_out samples; per-bit cost SETTLE_CYC+4; per comparator 2+6×(SETTLE_CYC+4) (default 50).
- Undefined: single-sample decision as above.

Decomposition:
- Package flash_cal_pkg: TRIM_W=5, CODE_W=6, state enum (IDLE, SETUP, APPLY, SETTLE, SAMPLE, WRITE, DONE), function code_from_u (offset-binary → saturated signed).
- Sub-module flash_cal_trim_map: combinational signed code → b_left/b_right, shared with the trim register file readout.

Test Plan:
- cap_out tied 1, defaults, start pulse → 4 writes, wr_addr 0..3, all wr_code=+31; cal_done at cycle 153.
- cap_out tied 0 → all wr_code=−31; b_right stays 0 throughout.
- Per-comparator model, cap_out=(code ≤ OFF[i]) with OFF={+5,−7,0,−31} → wr_code={+5,−7,0,−31}; trim bus obeys the mapping every cycle.
- abort at cycle 60 (comp 1 mid-search) → comp 0 written only, IDLE next cycle, outputs 0, no cal_done; a new start recalibrates from comp 0.
- rst asserted asynchronously mid-SETTLE → outputs 0 without clk edge, no wr_en; start pulsed at cycle 10 while busy is ignored (exactly 4 writes).
- CAL_MAJORITY_EN, cap_out pattern 1,0,1 per SAMPLE window → bit kept; cal_done at cycle 201.

Source files
------------

// File: rtl/flash_cal_pkg.sv
// Shared types and helpers for the flash ADC comparator offset calibration sequencer.
// Optional build macro: CAL_MAJORITY_EN (3-sample majority bit decision).
package flash_cal_pkg;

    localparam int TRIM_W = 5;
    localparam int CODE_W = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        APPLY,
        SETTLE,
        SAMPLE,
        WRITE,
        DONE
    } cal_state_t;

    // Offset-binary u to signed code u-32; flipping the MSB is the subtraction.
    // u=0 would give -32, which the trim bus cannot express, so it saturates to -31.
    function automatic logic signed [CODE_W-1:0] code_from_u(input logic [CODE_W-1:0] u);
        if (u == '0) begin
            return 6'sb100001;
        end
        return {~u[CODE_W-1], u[CODE_W-2:0]};
    endfunction

endpackage

// File: rtl/flash_cal_trim_map.sv
// Signed trim code to split left/right magnitude bus; also used by the trim register
// file readout so both paths agree on the mapping.
module flash_cal_trim_map
    import flash_cal_pkg::*;
(
    input  logic signed [CODE_W-1:0] code,
    output logic        [TRIM_W-1:0] b_left,
    output logic        [TRIM_W-1:0] b_right
);

    logic [TRIM_W-1:0] neg_mag;

    always_comb begin
        // -32 never reaches here (code_from_u saturates), so 5 bits hold the magnitude.
        neg_mag = TRIM_W'(-code);
        b_left  = '0;
        b_right = '0;
        if (code[CODE_W-1]) begin
            b_left = neg_mag;
        end else begin
            b_right = code[TRIM_W-1:0];
        end
    end

endmodule

// File: rtl/flash_cal_sequencer.sv
// Foreground offset calibration of the comparator bank: 6-bit SAR search per comparator.
// Optional build macro: CAL_MAJORITY_EN (each bit decided by majority of 3 samples).
module flash_cal_sequencer
    import flash_cal_pkg::*;
#(
    parameter int NUM_COMP   = 4,
    parameter int SEL_W      = 2,
    parameter int SETTLE_CYC = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     cap_out,
    output logic                     cal_mode,
    output logic [SEL_W-1:0]         comp_sel,
    output logic [TRIM_W-1:0]        b_left,
    output logic [TRIM_W-1:0]        b_right,
    output logic                     wr_en,
    output logic [SEL_W-1:0]         wr_addr,
    output logic signed [CODE_W-1:0] wr_code,
    output logic                     cal_busy,
    output logic                     cal_done
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    cal_state_t               state_reg;
    logic [CODE_W-1:0]        u_reg;
    logic [2:0]               bit_reg;
    logic [CNT_W-1:0]         cnt_reg;

    logic                     cal_mode_reg;
    logic [SEL_W-1:0]         comp_sel_reg;
    logic [TRIM_W-1:0]        b_left_reg;
    logic [TRIM_W-1:0]        b_right_reg;
    logic                     wr_en_reg;
    logic [SEL_W-1:0]         wr_addr_reg;
    logic signed [CODE_W-1:0] wr_code_reg;
    logic                     cal_busy_reg;
    logic                     cal_done_reg;

    logic [CODE_W-1:0]        bit_mask;
    logic [CODE_W-1:0]        u_trial;
    logic [CODE_W-1:0]        u_dec;
    logic signed [CODE_W-1:0] trial_code;
    logic [TRIM_W-1:0]        map_left;
    logic [TRIM_W-1:0]        map_right;
    logic                     sample_last;
    logic                     bit_keep;

`ifdef CAL_MAJORITY_EN
    logic [1:0]               smp_reg;
    logic [1:0]               smp_cnt_reg;
`endif

    always_comb begin
        bit_mask   = CODE_W'(1) << bit_reg;
        u_trial    = u_reg | bit_mask;
        trial_code = code_from_u(u_trial);
`ifdef CAL_MAJORITY_EN
        sample_last = (smp_cnt_reg == 2'd2);
        bit_keep    = (smp_reg[0] & smp_reg[1]) | (cap_out & (smp_reg[0] | smp_reg[1]));
`else
        sample_last = 1'b1;
        bit_keep    = cap_out;
`endif
        u_dec = bit_keep ? u_reg : (u_reg & ~bit_mask);
    end

    flash_cal_trim_map u_trim_map (
        .code    (trial_code),
        .b_left  (map_left),
        .b_right (map_right)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            u_reg        <= '0;
            bit_reg      <= 3'd5;
            cnt_reg      <= '0;
            cal_mode_reg <= 1'b0;
            comp_sel_reg <= '0;
            b_left_reg   <= '0;
            b_right_reg  <= '0;
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_code_reg  <= '0;
            cal_busy_reg <= 1'b0;
            cal_done_reg <= 1'b0;
`ifdef CAL_MAJORITY_EN
            smp_reg      <= '0;
            smp_cnt_reg  <= '0;
`endif
        end else begin
            wr_en_reg    <= 1'b0;
            wr_addr_reg  <= '0;
            wr_code_reg  <= '0;
            cal_done_reg <= 1'b0;
            // abort outranks every transition, including a pending write
            if (abort && state_reg != IDLE) begin
                state_reg    <= IDLE;
                u_reg        <= '0;
                bit_reg      <= 3'd5;
                cnt_reg      <= '0;
                cal_mode_reg <= 1'b0;
                comp_sel_reg <= '0;
                b_left_reg   <= '0;
                b_right_reg  <= '0;
                cal_busy_reg <= 1'b0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start && !abort) begin
                            state_reg    <= SETUP;
                            comp_sel_reg <= '0;
                            cal_mode_reg <= 1'b1;
                            cal_busy_reg <= 1'b1;
                        end
                    end
                    SETUP: begin
                        u_reg     <= '0;
                        bit_reg   <= 3'd5;
                        state_reg <= APPLY;
                    end
                    APPLY: begin
                        u_reg       <= u_trial;
                        b_left_reg  <= map_left;
                        b_right_reg <= map_right;
                        cnt_reg     <= CNT_W'(SETTLE_CYC);
                        state_reg   <= SETTLE;
                    end
                    SETTLE: begin
                        if (cnt_reg == CNT_W'(1)) begin
                            state_reg <= SAMPLE;
`ifdef CAL_MAJORITY_EN
                            smp_cnt_reg <= '0;
`endif
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    SAMPLE: begin
`ifdef CAL_MAJORITY_EN
                        if (!sample_last) begin
                            smp_reg     <= {smp_reg[0], cap_out};
                            smp_cnt_reg <= smp_cnt_reg + 2'd1;
                        end
`endif
                        if (sample_last) begin
                            u_reg <= u_dec;
                            if (bit_reg == 3'd0) begin
                                state_reg   <= WRITE;
                                wr_en_reg   <= 1'b1;
                                wr_addr_reg <= comp_sel_reg;
                                wr_code_reg <= code_from_u(u_dec);
                                b_left_reg  <= '0;
                                b_right_reg <= '0;
                            end else begin
                                bit_reg   <= bit_reg - 3'd1;
                                state_reg <= APPLY;
                            end
                        end
                    end
                    WRITE: begin
                        if (comp_sel_reg == SEL_W'(NUM_COMP - 1)) begin
                            state_reg    <= DONE;
                            cal_mode_reg <= 1'b0;
                            cal_done_reg <= 1'b1;
                        end else begin
                            comp_sel_reg <= comp_sel_reg + SEL_W'(1);
                            state_reg    <= SETUP;
                        end
                    end
                    DONE: begin
                        state_reg    <= IDLE;
                        comp_sel_reg <= '0;
                        cal_busy_reg <= 1'b0;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

    assign cal_mode = cal_mode_reg;
    assign comp_sel = comp_sel_reg;
    assign b_left   = b_left_reg;
    assign b_right  = b_right_reg;
    assign wr_en    = wr_en_reg;
    assign wr_addr  = wr_addr_reg;
    assign wr_code  = wr_code_reg;
    assign cal_busy = cal_busy_reg;
    assign cal_done = cal_done_reg;

endmodule

// File: tb/tb_flash_cal_sequencer.sv
// Directed bench for flash_cal_sequencer: table of full calibrations plus abort/reset/start corners.
module tb_flash_cal_sequencer;

`ifdef CAL_MAJORITY_EN
    localparam int PER_COMP = 50;
    localparam int NV       = 5;
`else
    localparam int PER_COMP = 38;
    localparam int NV       = 4;
`endif
    localparam int EXP_DONE = 4 * PER_COMP + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic              cap_out;
    logic              cal_mode;
    logic [1:0]        comp_sel;
    logic [4:0]        b_left;
    logic [4:0]        b_right;
    logic              wr_en;
    logic [1:0]        wr_addr;
    logic signed [5:0] wr_code;
    logic              cal_busy;
    logic              cal_done;

    flash_cal_sequencer #(.NUM_COMP(4), .SEL_W(2), .SETTLE_CYC(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .cap_out  (cap_out),
        .cal_mode (cal_mode),
        .comp_sel (comp_sel),
        .b_left   (b_left),
        .b_right  (b_right),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_code  (wr_code),
        .cal_busy (cal_busy),
        .cal_done (cal_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // cap_out modes: 0 tied low, 1 tied high, 2 comparator offset model, 3 1/0/1 per sample window
    int mode = 1;
    int start_cyc = 0;
    int off_arr [4];
    int trial, rel_c, p_c, q_c;

    always_comb begin
        cap_out = 1'b0;
        trial   = int'(b_right) - int'(b_left);
        rel_c   = cyc - start_cyc + 1;
        p_c     = (rel_c - 1) % PER_COMP;
        q_c     = (p_c - 1) % 8;
        case (mode)
            0: cap_out = 1'b0;
            1: cap_out = 1'b1;
            2: cap_out = (trial <= off_arr[comp_sel]);
            3: cap_out = (q_c != 6);
            default: cap_out = 1'b0;
        endcase
    end

    typedef struct {
        int mode;
        int o0, o1, o2, o3;
        int e0, e1, e2, e3;
        bit no_right;
    } vec_t;

    vec_t vecs [NV];

    int n_tot = 0;
    int n_bad = 0;
    int wr_cnt, done_cnt, done_rel, bus_bad, bright_seen;
    int wr_addr_log [8];
    int wr_code_log [8];
    int wr_rel_log  [8];
    int exp_code [4];

    task automatic check(input string name, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_logs();
        wr_cnt = 0; done_cnt = 0; done_rel = -1; bus_bad = 0; bright_seen = 0;
    endtask

    // one clock, observing outputs at the falling edge
    task automatic step();
        int r;
        @(negedge clk);
        r = cyc - start_cyc + 1;
        if (wr_en) begin
            if (wr_cnt < 8) begin
                wr_addr_log[wr_cnt] = int'(wr_addr);
                wr_code_log[wr_cnt] = int'(wr_code);
                wr_rel_log[wr_cnt]  = r;
            end
            wr_cnt++;
        end
        if (cal_done) begin
            done_cnt++;
            done_rel = r;
        end
        if (b_left != 0 && b_right != 0) bus_bad++;
        if (!cal_busy && (b_left != 0 || b_right != 0 || cal_mode || wr_en)) bus_bad++;
        if ((wr_en || cal_done) && (b_left != 0 || b_right != 0)) bus_bad++;
        if (b_right != 0) bright_seen = 1;
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start_cyc = cyc;
        start = 1'b0;
    endtask

    task automatic step_to_rel(input int target);
        int guard;
        guard = 0;
        while ((cyc - start_cyc + 1) < target && guard < 1000) begin
            step();
            guard++;
        end
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while (done_cnt == 0 && guard < 400) begin
            step();
            guard++;
        end
        if (done_cnt == 0) check("done_timeout", 0, 1);
        repeat (3) step();
    endtask

    task automatic check_writes(input string tag, input int n);
        check({tag, "_wr_cnt"}, wr_cnt, n);
        for (int i = 0; i < n && i < wr_cnt && i < 8; i++) begin
            check($sformatf("%s_addr%0d", tag, i), wr_addr_log[i], i);
            check($sformatf("%s_code%0d", tag, i), wr_code_log[i], exp_code[i]);
            check($sformatf("%s_wrcyc%0d", tag, i), wr_rel_log[i], (i + 1) * PER_COMP);
        end
    endtask

    initial begin
        vecs[0] = '{1, 0, 0, 0, 0, 31, 31, 31, 31, 1'b0};
        vecs[1] = '{0, 0, 0, 0, 0, -31, -31, -31, -31, 1'b1};
        vecs[2] = '{2, 5, -7, 0, -31, 5, -7, 0, -31, 1'b0};
        vecs[3] = '{2, 31, -1, 1, -30, 31, -1, 1, -30, 1'b0};
`ifdef CAL_MAJORITY_EN
        vecs[4] = '{3, 0, 0, 0, 0, 31, 31, 31, 31, 1'b0};
`endif
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        clear_logs();
        repeat (3) @(negedge clk);
        check("rst_busy", int'(cal_busy), 0);
        check("rst_mode", int'(cal_mode), 0);
        check("rst_wr_en", int'(wr_en), 0);
        check("rst_bus", int'({b_left, b_right}), 0);
        check("rst_done", int'(cal_done), 0);
        rst = 1'b0;
        repeat (2) step();
        check("idle_busy", int'(cal_busy), 0);

        for (int v = 0; v < NV; v++) begin
            mode = vecs[v].mode;
            off_arr[0] = vecs[v].o0; off_arr[1] = vecs[v].o1;
            off_arr[2] = vecs[v].o2; off_arr[3] = vecs[v].o3;
            exp_code[0] = vecs[v].e0; exp_code[1] = vecs[v].e1;
            exp_code[2] = vecs[v].e2; exp_code[3] = vecs[v].e3;
            clear_logs();
            launch();
            check($sformatf("v%0d_busy", v), int'(cal_busy), 1);
            wait_done();
            check_writes($sformatf("v%0d", v), 4);
            check($sformatf("v%0d_done_cyc", v), done_rel, EXP_DONE);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_bus", v), bus_bad, 0);
            if (vecs[v].no_right) check($sformatf("v%0d_bright", v), bright_seen, 0);
            $display("vector %0d mode=%0d writes=%0d done_cyc=%0d", v, mode, wr_cnt, done_rel);
        end

        // abort mid-search of comparator 1
        mode = 2;
        off_arr[0] = 5; off_arr[1] = -7; off_arr[2] = 0; off_arr[3] = -31;
        exp_code[0] = 5; exp_code[1] = -7; exp_code[2] = 0; exp_code[3] = -31;
        clear_logs();
        launch();
        step_to_rel(60);
        check("abort_pre_sel", int'(comp_sel), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort_busy", int'(cal_busy), 0);
        check("abort_outs", int'({cal_mode, comp_sel, b_left, b_right, wr_en, wr_addr, wr_code, cal_done}), 0);
        repeat (60) step();
        check_writes("abort", 1);
        check("abort_no_done", done_cnt, 0);
        $display("abort at cycle 60 writes=%0d done=%0d", wr_cnt, done_cnt);

        // start together with abort in IDLE
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", int'(cal_busy), 0);
        step();
        check("start_abort_idle2", int'(cal_busy), 0);

        clear_logs();
        launch();
        wait_done();
        check_writes("recal", 4);
        check("recal_done_cyc", done_rel, EXP_DONE);
        $display("recalibration writes=%0d done_cyc=%0d", wr_cnt, done_rel);

        // asynchronous reset during SETTLE of bit 4
        mode = 1;
        clear_logs();
        launch();
        step_to_rel(11);
        check("pre_rst_bright", int'(b_right), 16);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", int'(cal_busy), 0);
        check("arst_mode", int'(cal_mode), 0);
        check("arst_bus", int'({b_left, b_right}), 0);
        check("arst_wr_en", int'(wr_en), 0);
        repeat (2) step();
        rst = 1'b0;
        repeat (3) step();
        check("arst_no_write", wr_cnt, 0);
        $display("async reset mid-settle busy=%0d writes=%0d", cal_busy, wr_cnt);

        // start while busy is ignored
        exp_code[0] = 31; exp_code[1] = 31; exp_code[2] = 31; exp_code[3] = 31;
        clear_logs();
        launch();
        step_to_rel(10);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        check_writes("busy_start", 4);
        check("busy_start_done_cyc", done_rel, EXP_DONE);
        repeat (20) step();
        check("busy_start_idle", int'(cal_busy), 0);
        check("busy_start_total", wr_cnt, 4);
        $display("start while busy writes=%0d done_cyc=%0d", wr_cnt, done_rel);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
